// File: rtl/task_sequencer_if.sv
// Handshake bundle between a task sequencer and its task channels.
// The sequencer takes the slave modport; the driver of enable/mask/done takes master.
interface task_sequencer_if #(
    parameter int NUM_TASKS = 4
) ();
    logic                         enable;
    logic [NUM_TASKS-1:0]         task_mask;
    logic [NUM_TASKS-1:0]         done;
    logic [NUM_TASKS-1:0]         grant;
    logic [$clog2(NUM_TASKS)-1:0] active_idx;
    logic                         busy;
    logic                         round_done;
    logic                         timeout;
    logic                         led;

    modport slave (
        input  enable, task_mask, done,
        output grant, active_idx, busy, round_done, timeout, led
    );

    modport master (
        output enable, task_mask, done,
        input  grant, active_idx, busy, round_done, timeout, led
    );
endinterface

// File: rtl/task_sequencer.sv
// Round-robin task sequencer: one-hot grant, one-cycle gap between grants.
// Optional watchdog abort enabled by defining TASK_SEQ_TIMEOUT_EN.
module task_sequencer #(
    parameter int NUM_TASKS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst_n,
    task_sequencer_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_TASKS);

    if (NUM_TASKS < 2 || NUM_TASKS > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("task_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t               state_q, state_d;
    logic [NUM_TASKS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 rd_q, rd_d;
    logic                 first_q, first_d;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand;
    logic                 start;
`ifdef TASK_SEQ_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]          cnt_q, cnt_d;
    logic                 to_q, to_d;
`endif

    // Upward search from last+1 with wrap; iterating from the far end lets the nearest hit win.
    always_comb begin
        sel_idx = '0;
        cand    = '0;
        for (int k = NUM_TASKS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(last_q) + 1 + k) % NUM_TASKS);
            if (bus.task_mask[cand]) sel_idx = cand;
        end
    end

    assign start = bus.enable && (|bus.task_mask);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        rd_d    = 1'b0;
        first_d = first_q;
`ifdef TASK_SEQ_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE, GAP: begin
                grant_d = '0;
                if (start) begin
                    state_d          = GRANT;
                    idx_d            = sel_idx;
                    grant_d[sel_idx] = 1'b1;
                    rd_d             = !first_q && (sel_idx <= last_q);
                    first_d          = 1'b0;
`ifdef TASK_SEQ_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Only the granted channel's done is looked at; done wins over expiry.
                if (bus.done[idx_q]) begin
                    state_d = GAP;
                    grant_d = '0;
                    last_d  = idx_q;
                end
`ifdef TASK_SEQ_TIMEOUT_EN
                else if (cnt_q == LIMIT) begin
                    state_d = GAP;
                    grant_d = '0;
                    last_d  = idx_q;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_TASKS - 1);
            rd_q    <= 1'b0;
            first_q <= 1'b1;
`ifdef TASK_SEQ_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            first_q <= first_d;
`ifdef TASK_SEQ_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.grant      = grant_q;
    assign bus.active_idx = idx_q;
    assign bus.busy       = |grant_q;
    assign bus.led        = |grant_q;
    assign bus.round_done = rd_q;
`ifdef TASK_SEQ_TIMEOUT_EN
    assign bus.timeout    = to_q;
`else
    assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_task_sequencer.sv
// Directed bench for task_sequencer (NUM_TASKS=4, TIMEOUT_CYCLES=8).
module tb_task_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task_sequencer_if #(.NUM_TASKS(4)) bus ();

    task_sequencer #(.NUM_TASKS(4), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] g, input logic rd, input logic to);
        check({tag, ".grant"}, 16'(bus.grant), 16'(g));
        check({tag, ".busy"}, 16'(bus.busy), 16'(|g));
        check({tag, ".led"}, 16'(bus.led), 16'(|g));
        check({tag, ".round_done"}, 16'(bus.round_done), 16'(rd));
        check({tag, ".timeout"}, 16'(bus.timeout), 16'(to));
    endtask

    logic [3:0] seq_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       seq_r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        bus.enable    = 1'b0;
        bus.task_mask = 4'b0000;
        bus.done      = 4'b0000;

        // Reset state
        #1;
        chk("reset", 4'b0000, 1'b0, 1'b0);
        check("reset.active_idx", 16'(bus.active_idx), 16'd0);
        tick();
        chk("reset_clk", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Empty mask: stay idle, then a single bit is granted one cycle later
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("empty_mask", 4'b0000, 1'b0, 1'b0);
        end
        bus.task_mask = 4'b0100;
        tick();
        chk("mask_0100", 4'b0100, 1'b0, 1'b0);
        check("mask_0100.active_idx", 16'(bus.active_idx), 16'd2);
        bus.done = 4'b0100;
        tick();
        chk("mask_0100_done", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        bus.enable = 1'b0;
        bus.task_mask = 4'b0000;
        tick();
        chk("idle_again", 4'b0000, 1'b0, 1'b0);

        // Fresh reset, then full round-robin over 1111
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.task_mask = 4'b1111;
        bus.enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("rr%0d.first", n), seq_g[n], seq_r[n], 1'b0);
            tick();
            chk($sformatf("rr%0d.hold", n), seq_g[n], 1'b0, 1'b0);
            tick();
            bus.done = seq_g[n];
            tick();
            chk($sformatf("rr%0d.gap", n), 4'b0000, 1'b0, 1'b0);
            bus.done = 4'b0000;
        end
        bus.enable = 1'b0;
        tick();
        chk("rr.idle", 4'b0000, 1'b0, 1'b0);

        // Mask 1010, stray done[0] ignored; last is 0 here
        bus.task_mask = 4'b1010;
        bus.enable = 1'b1;
        tick();
        chk("m1010.a", 4'b0010, 1'b0, 1'b0);
        bus.done = 4'b0001;
        tick();
        chk("m1010.stray", 4'b0010, 1'b0, 1'b0);
        bus.done = 4'b0010;
        tick();
        chk("m1010.gap1", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        tick();
        chk("m1010.b", 4'b1000, 1'b0, 1'b0);
        bus.done = 4'b1000;
        tick();
        chk("m1010.gap2", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        tick();
        chk("m1010.c", 4'b0010, 1'b1, 1'b0);
        bus.done = 4'b0010;
        bus.enable = 1'b0;
        tick();
        chk("m1010.gap3", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        tick();
        chk("m1010.idle", 4'b0000, 1'b0, 1'b0);

        // Enable and mask dropped mid-grant do not revoke it; last is 1 here
        bus.task_mask = 4'b1111;
        bus.enable = 1'b1;
        tick();
        chk("en.grant", 4'b0100, 1'b0, 1'b0);
        bus.enable = 1'b0;
        bus.task_mask = 4'b0000;
        tick();
        chk("en.hold1", 4'b0100, 1'b0, 1'b0);
        tick();
        chk("en.hold2", 4'b0100, 1'b0, 1'b0);
        bus.done = 4'b0100;
        tick();
        chk("en.gap", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        tick();
        chk("en.idle1", 4'b0000, 1'b0, 1'b0);
        tick();
        chk("en.idle2", 4'b0000, 1'b0, 1'b0);
        bus.enable = 1'b1;
        bus.task_mask = 4'b1111;
        tick();
        chk("en.regrant", 4'b1000, 1'b0, 1'b0);
        check("en.regrant.active_idx", 16'(bus.active_idx), 16'd3);

        // Asynchronous reset mid-grant drops grant before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst", 4'b0000, 1'b0, 1'b0);
        check("arst.active_idx", 16'(bus.active_idx), 16'd0);
        bus.task_mask = 4'b0110;
        tick();
        chk("arst.held", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("arst.first", 4'b0010, 1'b0, 1'b0);
        check("arst.first.active_idx", 16'(bus.active_idx), 16'd1);
        bus.done = 4'b0010;
        tick();
        chk("arst.gap", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
        bus.task_mask = 4'b0011;
        tick();
        chk("wd.grant0", 4'b0001, 1'b1, 1'b0);

`ifdef TASK_SEQ_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("wd.hold%0d", i), 4'b0001, 1'b0, 1'b0);
        end
        tick();
        chk("wd.expire", 4'b0000, 1'b0, 1'b1);
        tick();
        chk("wd.next", 4'b0010, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("wd2.hold%0d", i), 4'b0010, 1'b0, 1'b0);
        end
        bus.done = 4'b0010;
        tick();
        chk("wd2.done_wins", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
`else
        for (int i = 1; i < 20; i++) begin
            tick();
            chk($sformatf("nowd.hold%0d", i), 4'b0001, 1'b0, 1'b0);
        end
        bus.done = 4'b0001;
        tick();
        chk("nowd.done", 4'b0000, 1'b0, 1'b0);
        bus.done = 4'b0000;
`endif
        bus.enable = 1'b0;
        tick();
        chk("final.idle", 4'b0000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/task_sequencer.md
TASK_SEQUENCER -- requirements
Module: task_sequencer

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 4: number of task channels, legal range 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clk cycles, legal range 2..65535, used only with TASK_SEQ_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1: permits dispatch of new grants.
REQ-006 SHALL have port task_mask, input, NUM_TASKS: bit i=1 makes task i eligible.
REQ-007 SHALL have port done, input, NUM_TASKS: per-task completion, level-sampled each edge.
REQ-008 SHALL have port grant, output, NUM_TASKS: registered, one-hot or all-zero.
REQ-009 SHALL have port active_idx, output, $clog2(NUM_TASKS): index of the current or most recent grant.
REQ-010 SHALL have port busy, output, 1: equals |grant.
REQ-011 SHALL have port round_done, output, 1: one-cycle pulse on round-robin wrap.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on watchdog abort.
REQ-013 SHALL have port led, output, 1: equals busy.

Function
REQ-014 SHALL implement three states: IDLE (grant=0), GRANT (grant[active_idx]=1), GAP (grant=0, exactly one cycle).
REQ-015 SHALL select the next task as the first set bit of task_mask searching upward from (last+1) mod NUM_TASKS with wrap; last is the index of the most recently completed task.
REQ-016 In IDLE, with enable=1 and |task_mask=1 at edge k, SHALL assert grant of the selected task from edge k and enter GRANT; otherwise it SHALL remain in IDLE.
REQ-017 In GRANT, with done[active_idx]=1 at an edge, SHALL deassert grant at that edge, set last=active_idx and enter GAP.
REQ-018 SHALL ignore done bits of non-granted tasks.
REQ-019 SHALL NOT let task_mask or enable changes during GRANT revoke the current grant.
REQ-020 From GAP, with enable=1 and |task_mask=1, SHALL enter GRANT with a fresh selection; otherwise it SHALL enter IDLE.
- Back-to-back turnaround: exactly one all-zero grant cycle.
REQ-021 With a single eligible task, SHALL re-grant the same task after GAP.
REQ-022 SHALL pulse round_done in the first cycle of any grant whose index is less than or equal to last, excluding the first grant after reset.

Reset
REQ-023 While rst_n=0, SHALL asynchronously force state=IDLE, grant=0, busy=0, led=0, round_done=0, timeout=0, active_idx=0, last=NUM_TASKS-1 and the watchdog count to 0.
REQ-024 Reset asserted mid-GRANT SHALL drop grant without waiting for a clock edge.
REQ-025 After reset release, the first grant SHALL go to the lowest set bit of task_mask.

Configuration
REQ-026 Macro TASK_SEQ_TIMEOUT_EN defined: SHALL clear a 16-bit watchdog count on GRANT entry and increment it each GRANT cycle; after TIMEOUT_CYCLES GRANT cycles without done, it SHALL abort (treated as completion, enter GAP) and pulse timeout during the GAP cycle.
REQ-027 If done is sampled high on the expiry edge, done SHALL take precedence and timeout SHALL stay 0.
REQ-028 Macro TASK_SEQ_TIMEOUT_EN undefined: SHALL omit the watchdog logic, tie timeout to 0 and hold a grant indefinitely until done.

Verification
REQ-029 SHALL cover: NUM_TASKS=4, task_mask=1111, enable=1, done 3 cycles after each grant -> grant 0001,0010,0100,1000,0001, one zero cycle between grants, round_done with the second 0001.
REQ-030 SHALL cover: task_mask=1010, done[0] pulsed during grant=0010 -> pulse ignored; sequence 0010,1000,0010.
REQ-031 SHALL cover: enable dropped during grant=0100 -> grant held until done[2], then GAP, then IDLE with grant=0; enable re-raised -> grant=1000.
REQ-032 SHALL cover: with macro defined, TIMEOUT_CYCLES=8 and no done -> grant=0001 drops after 8 cycles, timeout pulses for 1 cycle, then grant=0010; done on the expiry edge -> timeout stays 0.
REQ-033 SHALL cover: rst_n low mid-grant -> grant=0 before the next edge; after release with task_mask=0110 -> first grant=0010.
REQ-034 SHALL cover: task_mask=0000, enable=1 -> stays in IDLE with busy=0 indefinitely; task_mask=0100 -> grant=0100 one cycle later.
